// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter feeding bytes from several requesters to one UART transmitter
//
// Purpose: selects one requester at a time (round-robin, most recently
// served requester has lowest priority), latches its byte, pulses the
// transmitter start, and waits for the transmitter completion pulse.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN enables a WAIT-state watchdog
// that returns to IDLE after p_timeout_cycles without i_tx_done.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-low reset
//   i_req       per-requester send request (level)
//   i_data      request bytes, requester k on [8k+7:8k]
//   o_gnt       one-hot grant pulse (byte accepted), only in START
//   o_tx_start  one-cycle start pulse to the transmitter, only in START
//   o_tx_data   latched byte presented to the transmitter
//   i_tx_done   transmitter completion pulse, sampled only in WAIT
//   o_busy      high in START and WAIT
//   o_owner     current or most recent granted requester
//   o_timeout   one-cycle watchdog expiry pulse (0 without the macro)

module uart_tx_arb #(
   parameter int p_num_req        = 4,
   parameter int p_timeout_cycles = 100000
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [p_num_req-1:0]   i_req,
   input  logic [8*p_num_req-1:0] i_data,
   output logic [p_num_req-1:0]   o_gnt,
   output logic                   o_tx_start,
   output logic [7:0]             o_tx_data,
   input  logic                   i_tx_done,
   output logic                   o_busy,
   output logic [2:0]             o_owner,
   output logic                   o_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] last_q;
   logic [2:0] sel;
   logic       found;
   logic [7:0] sel_data;
   logic       wd_expire;
   int         idx;

   // Search starts one past the last served index and wraps, so the last
   // owner is considered only after everyone else.
   always_comb begin
      sel   = last_q;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= p_num_req; i++) begin
         idx = int'(last_q) + i;
         if (idx >= p_num_req) idx = idx - p_num_req;
         for (int k = 0; k < p_num_req; k++) begin
            if (!found && (k == idx) && i_req[k]) begin
               found = 1'b1;
               sel   = 3'(k);
            end
         end
      end
   end

   always_comb begin
      sel_data = 8'h00;
      for (int k = 0; k < p_num_req; k++) begin
         if (sel == 3'(k)) sel_data = i_data[8*k +: 8];
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(p_timeout_cycles + 1);
   logic [CW-1:0] wd_q;

   // START always precedes WAIT, so clearing in START clears on every entry.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wd_q <= '0;
      end else if (state_q == ST_START) begin
         wd_q <= '0;
      end else if (state_q == ST_WAIT) begin
         wd_q <= wd_q + CW'(1);
      end
   end

   assign wd_expire = (state_q == ST_WAIT) && (wd_q == CW'(p_timeout_cycles - 1));
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= ST_IDLE;
         last_q    <= 3'(p_num_req - 1);
         o_owner   <= 3'd0;
         o_tx_data <= 8'h00;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_IDLE) && found) begin
            last_q    <= sel;
            o_owner   <= sel;
            o_tx_data <= sel_data;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      o_gnt      = '0;
      o_tx_start = 1'b0;
      o_timeout  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found) state_d = ST_START;
         end
         ST_START: begin
            o_tx_start = 1'b1;
            for (int k = 0; k < p_num_req; k++) begin
               o_gnt[k] = (o_owner == 3'(k));
            end
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Completion on the expiry cycle wins over the watchdog.
            if (i_tx_done) begin
               state_d = ST_IDLE;
            end else if (wd_expire) begin
               o_timeout = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed self-checking bench for uart_tx_arb

module tb_uart_tx_arb;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  gnt;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        busy;
   logic [2:0]  owner;
   logic        timeout;

   int checks;
   int errors;

   uart_tx_arb #(
      .p_num_req        (4),
      .p_timeout_cycles (16)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_req      (req),
      .i_data     (data),
      .o_gnt      (gnt),
      .o_tx_start (tx_start),
      .o_tx_data  (tx_data),
      .i_tx_done  (tx_done),
      .o_busy     (busy),
      .o_owner    (owner),
      .o_timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      step();
      rst = 1'b0;
      req = 4'b0000;
      tx_done = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic pulse_done();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req = 4'b0000;
      data = 32'h0;
      tx_done = 1'b0;
      step();
      step();
      checks++;
      if ({gnt, tx_start, tx_data, busy, owner, timeout} !== {4'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got gnt=%b st=%b data=%h busy=%b own=%0d to=%b want all zero",
                  gnt, tx_start, tx_data, busy, owner, timeout);
      end
      rst = 1'b1;
      // done in IDLE must have no effect
      pulse_done();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL done_in_idle got busy=%b want 0", busy);
      end
   endtask

   task automatic test_single();
      apply_reset();
      data = 32'h0000_0041;
      req = 4'b0001;
      step();
      req = 4'b0000;
      checks++;
      if ({gnt, tx_start, tx_data, owner} !== {4'b0001, 1'b1, 8'h41, 3'd0}) begin
         errors++;
         $display("FAIL single_grant got gnt=%b st=%b data=%h own=%0d want 0001 1 41 0",
                  gnt, tx_start, tx_data, owner);
      end
      data = 32'h0000_00EE;
      step();
      checks++;
      if ({gnt, tx_start, busy, tx_data} !== {4'b0000, 1'b0, 1'b1, 8'h41}) begin
         errors++;
         $display("FAIL single_wait got gnt=%b st=%b busy=%b data=%h want 0000 0 1 41",
                  gnt, tx_start, busy, tx_data);
      end
      repeat (9) step();
      pulse_done();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done got busy=%b want 0", busy);
      end
   endtask

   task automatic test_round_robin();
      int order [5];
      order = '{0, 1, 2, 3, 0};
      apply_reset();
      data = 32'h1312_1110;
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         step();
         checks++;
         if ({gnt, tx_start, owner, tx_data} !== {4'(1 << order[n]), 1'b1, 3'(order[n]), 8'(8'h10 + order[n])}) begin
            errors++;
            $display("FAIL rr_order[%0d] got gnt=%b st=%b own=%0d data=%h want owner %0d",
                     n, gnt, tx_start, owner, tx_data, order[n]);
         end
         step();
         pulse_done();
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_wrap();
      apply_reset();
      data = 32'hD0C0_B0A0;
      req = 4'b0100;
      step();
      req = 4'b0101;
      step();
      pulse_done();
      step();
      checks++;
      if ({gnt, owner, tx_data} !== {4'b0001, 3'd0, 8'hA0}) begin
         errors++;
         $display("FAIL wrap_first got gnt=%b own=%0d data=%h want 0001 0 a0", gnt, owner, tx_data);
      end
      step();
      pulse_done();
      step();
      checks++;
      if ({gnt, owner, tx_data} !== {4'b0100, 3'd2, 8'hC0}) begin
         errors++;
         $display("FAIL wrap_second got gnt=%b own=%0d data=%h want 0100 2 c0", gnt, owner, tx_data);
      end
      req = 4'b0000;
      step();
      pulse_done();
   endtask

   task automatic test_done_in_start();
      apply_reset();
      data = 32'h0000_3300;
      req = 4'b0010;
      step();
      req = 4'b0000;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      checks++;
      if ({busy, tx_start} !== {1'b1, 1'b0}) begin
         errors++;
         $display("FAIL done_in_start got busy=%b st=%b want 1 0", busy, tx_start);
      end
      repeat (3) step();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL wait_persist got busy=%b want 1", busy);
      end
      pulse_done();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL done_in_wait got busy=%b want 0", busy);
      end
   endtask

   task automatic test_dropped_req();
      apply_reset();
      req = 4'b0100;
      #3;
      req = 4'b0000;
      step();
      checks++;
      if ({gnt, tx_start, busy} !== {4'b0000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL dropped_req got gnt=%b st=%b busy=%b want 0000 0 0", gnt, tx_start, busy);
      end
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      data = 32'h0000_5A00;
      req = 4'b0010;
      step();
      req = 4'b0000;
      step();
      rst = 1'b0;
      #1;
      checks++;
      if ({gnt, tx_start, tx_data, busy, owner, timeout} !== {4'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset got gnt=%b st=%b data=%h busy=%b own=%0d to=%b want all zero",
                  gnt, tx_start, tx_data, busy, owner, timeout);
      end
      step();
      rst = 1'b1;
      data = 32'h7700_0000;
      req = 4'b1000;
      step();
      req = 4'b0000;
      checks++;
      if ({gnt, tx_start, owner, tx_data} !== {4'b1000, 1'b1, 3'd3, 8'h77}) begin
         errors++;
         $display("FAIL post_reset_grant got gnt=%b st=%b own=%0d data=%h want 1000 1 3 77",
                  gnt, tx_start, owner, tx_data);
      end
      step();
      pulse_done();
   endtask

   task automatic test_timeout();
      apply_reset();
      data = 32'h0000_2221;
      req = 4'b0001;
      step();
      req = 4'b0000;
      step();
`ifdef UART_ARB_TIMEOUT_EN
      repeat (14) step();
      checks++;
      if ({timeout, busy} !== {1'b0, 1'b1}) begin
         errors++;
         $display("FAIL timeout_early got to=%b busy=%b want 0 1", timeout, busy);
      end
      step();
      checks++;
      if (timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_pulse got to=%b want 1", timeout);
      end
      tx_done = 1'b1;
      #1;
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL done_precedence got to=%b want 0", timeout);
      end
      tx_done = 1'b0;
      #1;
      step();
      checks++;
      if ({timeout, busy} !== {1'b0, 1'b0}) begin
         errors++;
         $display("FAIL timeout_idle got to=%b busy=%b want 0 0", timeout, busy);
      end
      req = 4'b0011;
      step();
      req = 4'b0000;
      checks++;
      if ({gnt, owner, tx_data} !== {4'b0010, 3'd1, 8'h22}) begin
         errors++;
         $display("FAIL timeout_next got gnt=%b own=%0d data=%h want 0010 1 22", gnt, owner, tx_data);
      end
      step();
      pulse_done();
`else
      repeat (30) step();
      checks++;
      if ({timeout, busy} !== {1'b0, 1'b1}) begin
         errors++;
         $display("FAIL no_watchdog got to=%b busy=%b want 0 1", timeout, busy);
      end
      pulse_done();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL no_watchdog_done got busy=%b want 0", busy);
      end
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_done_in_start();
      test_dropped_req();
      test_reset_mid_wait();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // safety net so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1);
   end

endmodule
